// File: rtl/mmu_out_seq_pkg.sv
// Shared definitions for the MMU output sequencer: FSM state type and width helpers.
package mmu_out_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to represent value; clogb2(0) = 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((value >> i) != 0) bits = i + 1;
        end
        return bits;
    endfunction

    function automatic int unsigned width_min1(input int unsigned value);
        return (clogb2(value) < 1) ? 1 : clogb2(value);
    endfunction

endpackage

// File: rtl/mmu_out_seq_wrap_cnt.sv
// Wrapping counter 0..TARGET-1 with enable, synchronous clear and end-of-count flag.
module mmu_wrap_cnt
    import mmu_out_seq_pkg::*;
#(
    parameter int unsigned TARGET = 8,
    parameter int unsigned W      = width_min1(TARGET - 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_end
);

    localparam logic [W-1:0] LAST = W'(TARGET - 1);

    assign at_end = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmu_out_seq.sv
// MMU output sequencer: walks a ROWS x COLS tile row-major, one beat per valid/ready accept.
// Optional MMU_OUT_SEQ_BASE_EN adds a base_addr input captured at start and added to wr_addr.
module mmu_out_seq
    import mmu_out_seq_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 8,
    parameter int unsigned ADDR_W = width_min1(ROWS * COLS - 1),
    localparam int unsigned RW    = width_min1(ROWS - 1),
    localparam int unsigned CW    = width_min1(COLS - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
`ifdef MMU_OUT_SEQ_BASE_EN
    input  logic [ADDR_W-1:0] base_addr,
`endif
    output logic              out_valid,
    output logic [RW-1:0]     row_idx,
    output logic [CW-1:0]     col_idx,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic              accept;
    logic              run_abort;
    logic              final_acc;
    logic              cnt_clr;
    logic              col_end;
    logic              row_end;
    logic [ADDR_W-1:0] lin_addr;

    assign accept    = out_valid & out_ready;
    // Abort wins over a simultaneous accept: that beat counts as not delivered.
    assign run_abort = (state == S_RUN) & abort;
    assign final_acc = accept & col_end & row_end & ~run_abort;
    assign cnt_clr   = run_abort | final_acc;
    assign last      = row_end & col_end & out_valid;

    mmu_wrap_cnt #(.TARGET(COLS), .W(CW)) u_col_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept & ~run_abort),
        .clr    (cnt_clr),
        .cnt    (col_idx),
        .at_end (col_end)
    );

    mmu_wrap_cnt #(.TARGET(ROWS), .W(RW)) u_row_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept & col_end & ~run_abort),
        .clr    (cnt_clr),
        .cnt    (row_idx),
        .at_end (row_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin_addr <= '0;
        end else if (cnt_clr) begin
            lin_addr <= '0;
        end else if (accept) begin
            lin_addr <= lin_addr + 1'b1;
        end
    end

`ifdef MMU_OUT_SEQ_BASE_EN
    logic [ADDR_W-1:0] base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            base_q <= base_addr;
        end
    end

    assign wr_addr = base_q + lin_addr;
`else
    assign wr_addr = lin_addr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_abort) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (final_acc) begin
                        state     <= S_DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_out_seq.sv
// Self-checking bench for mmu_out_seq (2x3 tile) against a beat-index reference model.
module tb_mmu_out_seq;

    localparam int unsigned ROWS = 2;
    localparam int unsigned COLS = 3;
    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned AW   = 3;
    localparam int unsigned MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [0:0]    row_idx;
    logic [1:0]    col_idx;
    logic [AW-1:0] wr_addr;
    logic          last;
    logic          busy;
    logic          done;
    logic [AW-1:0] base_drv = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: a walk is just a beat index k in 0..N-1.
    bit m_walk = 0;
    bit m_done = 0;
    int m_k    = 0;
    int m_base = 0;

    always #5 clk = ~clk;

    mmu_out_seq #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
`ifdef MMU_OUT_SEQ_BASE_EN
        .base_addr (base_drv),
`endif
        .out_valid (out_valid),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .wr_addr   (wr_addr),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(m_walk));
        check_eq("busy", 32'(busy), 32'(m_walk | m_done));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("row_idx", 32'(row_idx), 32'(m_k / COLS));
        check_eq("col_idx", 32'(col_idx), 32'(m_k % COLS));
        check_eq("last", 32'(last), 32'(m_walk && (m_k == N - 1)));
`ifdef MMU_OUT_SEQ_BASE_EN
        check_eq("wr_addr", 32'(wr_addr), 32'((m_base + m_k) & MASK));
`else
        check_eq("wr_addr", 32'(wr_addr), 32'(m_k));
`endif
    endtask

    task automatic model_reset();
        m_walk = 0;
        m_done = 0;
        m_k    = 0;
        m_base = 0;
    endtask

    // One clock: check current outputs, apply inputs, advance the model at the edge.
    task automatic step(input logic s, input logic a, input logic r);
        @(negedge clk);
        check_outputs();
        start     = s;
        abort     = a;
        out_ready = r;
        @(posedge clk);
        if (m_done) begin
            m_done = 0;
        end else if (m_walk) begin
            if (a) begin
                m_walk = 0;
                m_k    = 0;
            end else if (r) begin
                if (m_k == N - 1) begin
                    m_walk = 0;
                    m_done = 1;
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end
        end else if (s) begin
            m_walk = 1;
            m_k    = 0;
            m_base = int'(base_drv);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Full-throughput walk
        step(1, 0, 1);
        for (int i = 0; i < N + 2; i++) step(0, 0, 1);

        // Ready toggling: every beat held one extra cycle
        step(1, 0, 1);
        for (int i = 0; i < 2 * N + 2; i++) step(0, 0, (i % 2) == 0);

        // Abort on the third beat, then restart from zero
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < N + 2; i++) step(0, 0, 1);

        // Abort while idle has no effect
        step(0, 1, 1);
        step(0, 1, 0);

        // start held high through the walk and DONE
        for (int i = 0; i < 2 * N + 4; i++) step(1, 0, 1);
        for (int i = 0; i < N + 2; i++) step(0, 0, 1);

        // Asynchronous reset in the middle of a walk
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1);
        for (int i = 0; i < N + 2; i++) step(0, 0, 1);

`ifdef MMU_OUT_SEQ_BASE_EN
        // Base near the top of the address space wraps; mid-walk changes ignored
        base_drv = 3'd6;
        step(1, 0, 1);
        step(0, 0, 1);
        base_drv = 3'd1;
        for (int i = 0; i < N + 2; i++) step(0, 0, 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            base_drv = AW'($urandom_range(0, MASK));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
        end
        step(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
